// File: rtl/num_conv_sched_if.sv
// Request/result bus for num_conv_sched.
// master: requesters plus result consumer. slave: the conversion engine.
interface num_conv_sched_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*8-1:0] req_data;
  logic [NREQ*3-1:0] req_fmt;
  logic [NREQ-1:0]   req_sign;
  logic              out_valid;
  logic              out_ready;
  logic [11:0]       out_data;
  logic [IDW-1:0]    out_id;
  logic              out_err;

  modport master (
    output req_valid, req_data, req_fmt, req_sign, out_ready,
    input  req_ready, out_valid, out_data, out_id, out_err
  );

  modport slave (
    input  req_valid, req_data, req_fmt, req_sign, out_ready,
    output req_ready, out_valid, out_data, out_id, out_err
  );
endinterface

// File: rtl/num_conv_sched.sv
// Round-robin arbitrated number-format conversion engine.
// Formats: sign-magnitude, one's/two's complement, BCD (serial double-dabble)
// and excess-3 BCD. One conversion in flight; result held until consumed.
// Optional macro NUM_CONV_STATS_EN adds handshake/error counters.
module num_conv_sched #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  num_conv_sched_if.slave   bus,
  output logic              busy
`ifdef NUM_CONV_STATS_EN
  ,
  output logic [15:0]       conv_count,
  output logic [7:0]        err_count
`endif
);

  typedef enum logic [1:0] {StIdle, StShift, StAdj, StDone} state_e;

  state_e         state_q;
  logic [IDW-1:0] ptr_q;
  logic [19:0]    sr_q;        // {bcd[11:0], binary[7:0]}
  logic [2:0]     cnt_q;
  logic           adj_q;
  logic           out_valid_q;
  logic [11:0]    out_data_q;
  logic [IDW-1:0] out_id_q;
  logic           out_err_q;

  logic           found;
  logic [IDW-1:0] win;
  logic [NREQ-1:0] gnt;
  logic [7:0]     win_data;
  logic [2:0]     win_fmt;
  logic           win_sign;
  logic [IDW-1:0] ptr_next;
  logic [19:0]    dd_next;

  // One double-dabble iteration: correct digits >= 5, then shift in next bit.
  function automatic logic [19:0] dd_step(logic [19:0] s);
    logic [19:0] t;
    t = s;
    for (int d = 0; d < 3; d++) begin
      if (t[8+4*d +: 4] >= 4'd5) t[8+4*d +: 4] = t[8+4*d +: 4] + 4'd3;
    end
    return {t[18:0], 1'b0};
  endfunction

  // Single-cycle formats; anything else yields zero.
  function automatic logic [11:0] simple_conv(logic [2:0] f, logic [7:0] n, logic s);
    logic [11:0] r;
    case (f)
      3'b000:  r = {4'b0, s, n[6:0]};
      3'b001:  r = {4'b0, ~n};
      3'b010:  r = {4'b0, 8'(~n + 8'd1)};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Round-robin search starting at the pointer, wrapping modulo NREQ.
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr_q) + k) % NREQ;
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  // Grant is one-hot and only offered while idle.
  always_comb begin
    gnt = '0;
    if (state_q == StIdle && found) gnt[win] = 1'b1;
  end

  assign bus.req_ready = gnt;
  assign win_data      = bus.req_data[32'(win)*8 +: 8];
  assign win_fmt       = bus.req_fmt[32'(win)*3 +: 3];
  assign win_sign      = bus.req_sign[win];
  assign ptr_next      = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
  assign dd_next       = dd_step(sr_q);

  // Control FSM with registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      sr_q        <= '0;
      cnt_q       <= '0;
      adj_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      out_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (found) begin
            ptr_q     <= ptr_next;
            out_id_q  <= win;
            out_err_q <= (win_fmt > 3'b100);
            if (win_fmt == 3'b011 || win_fmt == 3'b100) begin
              sr_q    <= {12'b0, win_data};
              cnt_q   <= '0;
              adj_q   <= (win_fmt == 3'b100);
              state_q <= StShift;
            end else begin
              out_data_q  <= simple_conv(win_fmt, win_data, win_sign);
              out_valid_q <= 1'b1;
              state_q     <= StDone;
            end
          end
        end
        StShift: begin
          sr_q  <= dd_next;
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            if (adj_q) begin
              state_q <= StAdj;
            end else begin
              out_data_q  <= dd_next[19:8];
              out_valid_q <= 1'b1;
              state_q     <= StDone;
            end
          end
        end
        StAdj: begin
          // Digits are <= 9, so +3 never carries between nibbles.
          out_data_q  <= {sr_q[19:16] + 4'd3, sr_q[15:12] + 4'd3, sr_q[11:8] + 4'd3};
          out_valid_q <= 1'b1;
          state_q     <= StDone;
        end
        StDone: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_id    = out_id_q;
  assign bus.out_err   = out_err_q;
  assign busy          = (state_q != StIdle);

`ifdef NUM_CONV_STATS_EN
  logic [15:0] conv_count_q;
  logic [7:0]  err_count_q;

  // Saturating counters of completed output handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_count_q <= '0;
      err_count_q  <= '0;
    end else if (out_valid_q && bus.out_ready) begin
      if (conv_count_q != 16'hFFFF) conv_count_q <= conv_count_q + 16'd1;
      if (out_err_q && err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
    end
  end

  assign conv_count = conv_count_q;
  assign err_count  = err_count_q;
`endif

endmodule

// File: tb/tb_num_conv_sched.sv
// Self-checking bench for num_conv_sched: scoreboard of expected results,
// pushed at accept and popped when the result appears.
module tb_num_conv_sched;
  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic busy;
`ifdef NUM_CONV_STATS_EN
  logic [15:0] conv_count;
  logic [7:0]  err_count;
`endif

  num_conv_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  num_conv_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
`ifdef NUM_CONV_STATS_EN
    ,
    .conv_count (conv_count),
    .err_count  (err_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [11:0]    data;
    logic [IDW-1:0] id;
    logic           err;
    int             lat;
    int             t_acc;
  } exp_t;

  exp_t sb[$];

  function automatic logic [11:0] bcd(logic [7:0] n);
    return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  function automatic exp_t model(int i, logic [7:0] n, logic [2:0] f, logic s);
    exp_t e;
    e.id = IDW'(i); e.err = 1'b0; e.lat = 1; e.t_acc = 0;
    case (f)
      3'b000: e.data = {4'h0, s, n[6:0]};
      3'b001: e.data = 12'(8'hFF - n);
      3'b010: e.data = 12'((256 - int'(n)) % 256);
      3'b011: begin e.data = bcd(n); e.lat = 9; end
      3'b100: begin e.data = bcd(n) + 12'h333; e.lat = 10; end
      default: begin e.data = '0; e.err = 1'b1; end
    endcase
    return e;
  endfunction

  task automatic drive_req(int i, logic [7:0] n, logic [2:0] f, logic s);
    bus.req_data[i*8 +: 8] = n;
    bus.req_fmt[i*3 +: 3]  = f;
    bus.req_sign[i]        = s;
    bus.req_valid[i]       = 1'b1;
  endtask

  // Called at a negedge with requests driven; returns after the accept edge.
  task automatic wait_accept(output int who, output bit ok);
    exp_t e;
    ok = 1'b0;
    who = -1;
    for (int k = 0; k < 30 && !ok; k++) begin
      #1;
      for (int i = 0; i < int'(NREQ); i++)
        if (bus.req_valid[i] && bus.req_ready[i]) who = i;
      if (who >= 0) begin
        e = model(who, bus.req_data[who*8 +: 8], bus.req_fmt[who*3 +: 3], bus.req_sign[who]);
        @(posedge clk);
        #1;
        e.t_acc = cyc;
        sb.push_back(e);
        bus.req_valid[who] = 1'b0;
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic wait_out(input int t_acc, output bit ok, output logic [11:0] d,
                          output logic [IDW-1:0] id, output logic err, output int lat);
    ok = 1'b0; d = '0; id = '0; err = 1'b0; lat = 0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        ok = 1'b1; d = bus.out_data; id = bus.out_id; err = bus.out_err;
        lat = cyc - t_acc + 1;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.out_data !== 12'h000 ||
        bus.req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset: got valid=%b busy=%b data=%h ready=%b, want 0 0 000 0000",
               bus.out_valid, busy, bus.out_data, bus.req_ready);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_bcd();
    int idx[4]          = '{0, 1, 2, 3};
    logic [7:0] val[4]  = '{8'd200, 8'd45, 8'd255, 8'd0};
    logic [2:0] fmt[4]  = '{3'b011, 3'b100, 3'b011, 3'b100};
    int who; bit ok_a, ok_o; logic [11:0] d; logic [IDW-1:0] id; logic err; int lat;
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive_req(idx[k], val[k], fmt[k], 1'b0);
      wait_accept(who, ok_a);
      checks++;
      if (!ok_a) begin
        errors++;
        $display("FAIL bcd_accept[%0d]: got no grant, want grant of req %0d", k, idx[k]);
        bus.req_valid = '0;
        continue;
      end
      wait_out(sb[0].t_acc, ok_o, d, id, err, lat);
      e = sb.pop_front();
      if (!ok_o || d !== e.data || id !== e.id || err !== e.err || lat != e.lat) begin
        errors++;
        $display("FAIL bcd[%0d]: got v=%b data=%h id=%0d err=%b lat=%0d, want data=%h id=%0d err=%b lat=%0d",
                 k, ok_o, d, id, err, lat, e.data, e.id, e.err, e.lat);
      end
    end
  endtask

  task automatic test_simple();
    int idx[5]          = '{2, 0, 1, 2, 3};
    logic [7:0] val[5]  = '{8'h05, 8'h85, 8'h85, 8'h0F, 8'h00};
    logic [2:0] fmt[5]  = '{3'b010, 3'b000, 3'b000, 3'b001, 3'b010};
    logic       sgn[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    int who; bit ok_a, ok_o; logic [11:0] d; logic [IDW-1:0] id; logic err; int lat;
    exp_t e;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive_req(idx[k], val[k], fmt[k], sgn[k]);
      wait_accept(who, ok_a);
      checks++;
      if (!ok_a) begin
        errors++;
        $display("FAIL simple_accept[%0d]: got no grant, want grant of req %0d", k, idx[k]);
        bus.req_valid = '0;
        continue;
      end
      wait_out(sb[0].t_acc, ok_o, d, id, err, lat);
      e = sb.pop_front();
      if (!ok_o || d !== e.data || id !== e.id || err !== e.err || lat != e.lat) begin
        errors++;
        $display("FAIL simple[%0d]: got v=%b data=%h id=%0d err=%b lat=%0d, want data=%h id=%0d err=%b lat=%0d",
                 k, ok_o, d, id, err, lat, e.data, e.id, e.err, e.lat);
      end
    end
  endtask

  task automatic test_arbitration();
    int want[3]             = '{0, 2, 3};
    logic [NREQ-1:0] rdy[3] = '{4'b0001, 4'b0100, 4'b1000};
    int who; bit ok_a, ok_o; logic [11:0] d; logic [IDW-1:0] id; logic err; int lat;
    exp_t e;
    @(negedge clk);
    drive_req(0, 8'h33, 3'b001, 1'b0);
    drive_req(2, 8'h7F, 3'b000, 1'b0);
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin
        @(negedge clk);
        for (int i = 0; i < int'(NREQ); i++) drive_req(i, 8'(i + 1), 3'b001, 1'b0);
      end else if (k == 1) begin
        @(negedge clk);
      end
      #1;
      checks++;
      if (bus.req_ready !== rdy[k]) begin
        errors++;
        $display("FAIL arb_ready[%0d]: got %b, want %b", k, bus.req_ready, rdy[k]);
      end
      wait_accept(who, ok_a);
      if (k == 2) bus.req_valid = '0;
      checks++;
      if (!ok_a || who != want[k]) begin
        errors++;
        $display("FAIL arb_grant[%0d]: got ok=%b who=%0d, want req %0d", k, ok_a, who, want[k]);
        bus.req_valid = '0;
        sb.delete();
        continue;
      end
      wait_out(sb[0].t_acc, ok_o, d, id, err, lat);
      e = sb.pop_front();
      if (!ok_o || d !== e.data || id !== e.id || err !== e.err || lat != e.lat) begin
        errors++;
        $display("FAIL arb_result[%0d]: got v=%b data=%h id=%0d err=%b lat=%0d, want data=%h id=%0d err=%b lat=%0d",
                 k, ok_o, d, id, err, lat, e.data, e.id, e.err, e.lat);
      end
    end
  endtask

  task automatic test_backpressure();
    int who; bit ok_a, ok_o; logic [11:0] d; logic [IDW-1:0] id; logic err; int lat;
    exp_t e;
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive_req(1, 8'hAA, 3'b101, 1'b0);
    wait_accept(who, ok_a);
    checks++;
    if (!ok_a) begin
      errors++;
      $display("FAIL bp_accept: got no grant, want grant of req 1");
      bus.req_valid = '0;
      bus.out_ready = 1'b1;
      return;
    end
    wait_out(sb[0].t_acc, ok_o, d, id, err, lat);
    e = sb.pop_front();
    drive_req(3, 8'h01, 3'b010, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== e.data || bus.out_id !== e.id ||
          bus.out_err !== e.err || bus.req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%b data=%h id=%0d err=%b ready=%b, want 1 %h %0d %b 0000",
                 k, bus.out_valid, bus.out_data, bus.out_id, bus.out_err, bus.req_ready,
                 e.data, e.id, e.err);
      end
    end
    checks++;
    if (!ok_o || d !== e.data || id !== e.id || err !== e.err || lat != e.lat) begin
      errors++;
      $display("FAIL bp_result: got v=%b data=%h id=%0d err=%b lat=%0d, want data=%h id=%0d err=%b lat=%0d",
               ok_o, d, id, err, lat, e.data, e.id, e.err, e.lat);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    wait_accept(who, ok_a);
    checks++;
    if (!ok_a || who != 3) begin
      errors++;
      $display("FAIL bp_next_grant: got ok=%b who=%0d, want req 3", ok_a, who);
      bus.req_valid = '0;
      sb.delete();
      return;
    end
    wait_out(sb[0].t_acc, ok_o, d, id, err, lat);
    e = sb.pop_front();
    checks++;
    if (!ok_o || d !== e.data || id !== e.id || err !== e.err || lat != e.lat) begin
      errors++;
      $display("FAIL bp_next_result: got v=%b data=%h id=%0d err=%b lat=%0d, want data=%h id=%0d err=%b lat=%0d",
               ok_o, d, id, err, lat, e.data, e.id, e.err, e.lat);
    end
  endtask

  task automatic test_reset_abort();
    int who; bit ok_a, ok_o; logic [11:0] d; logic [IDW-1:0] id; logic err; int lat;
    exp_t e;
    @(negedge clk);
    drive_req(2, 8'd123, 3'b011, 1'b0);
    wait_accept(who, ok_a);
    repeat (4) @(negedge clk);
    checks++;
    if (!ok_a || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_busy: got ok=%b busy=%b, want 1 1", ok_a, busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset: got valid=%b busy=%b, want 0 0", bus.out_valid, busy);
    end
    sb.delete();
    bus.req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive_req(0, 8'd99, 3'b011, 1'b0);
    drive_req(3, 8'h11, 3'b000, 1'b0);
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL abort_ptr: got ready=%b, want 0001", bus.req_ready);
    end
    wait_accept(who, ok_a);
    bus.req_valid = '0;
    checks++;
    if (!ok_a || who != 0) begin
      errors++;
      $display("FAIL abort_grant: got ok=%b who=%0d, want req 0", ok_a, who);
      sb.delete();
      return;
    end
    wait_out(sb[0].t_acc, ok_o, d, id, err, lat);
    e = sb.pop_front();
    if (!ok_o || d !== e.data || id !== e.id || err !== e.err || lat != e.lat) begin
      errors++;
      $display("FAIL abort_result: got v=%b data=%h id=%0d err=%b lat=%0d, want data=%h id=%0d err=%b lat=%0d",
               ok_o, d, id, err, lat, e.data, e.id, e.err, e.lat);
    end
`ifdef NUM_CONV_STATS_EN
    @(negedge clk);
    checks++;
    if (conv_count !== 16'd1 || err_count !== 8'd0) begin
      errors++;
      $display("FAIL stats: got conv=%0d err=%0d, want 1 0", conv_count, err_count);
    end
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_fmt   = '0;
    bus.req_sign  = '0;
    bus.out_ready = 1'b1;
    #1 rst_n = 1'b0;
    test_reset();
    test_bcd();
    test_simple();
    test_arbitration();
    test_backpressure();
    test_reset_abort();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/num_conv_sched.md
Name: num_conv_sched

Overview:
- Shared number-format conversion engine with a round-robin arbiter in front of it.
- NREQ requesters each present an 8-bit operand, a 3-bit format code and a sign bit.
- The block grants one requester at a time and runs the selected conversion: sign-magnitude, one's complement, two's complement, BCD or excess-3 BCD.
- BCD uses serial double-dabble. The result is returned on a single valid/ready output port tagged with the requester id.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of out_id; must satisfy 2^IDW >= NREQ.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request.
- req_ready  out  NREQ  one-hot grant/accept; request i is accepted when req_valid[i] & req_ready[i].
- req_data  in  NREQ*8  operand i at bits [8i+7:8i].
- req_fmt  in  NREQ*3  format i at bits [3i+2:3i].
- req_sign  in  NREQ  sign bit for sign-magnitude.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  12  conversion result, zero-extended.
- out_id  out  IDW  index of the requester that owns the result.
- out_err  out  1  reserved or illegal format; qualified by out_valid.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, round-robin pointer 0, internal registers 0. Reset is asynchronous; it aborts any conversion and drops out_valid immediately.
- States: IDLE, SHIFT, ADJ, DONE.
- IDLE arbitration:
  - Search starts at the pointer and wraps modulo NREQ; the first i with req_valid[i] wins.
  - req_ready[i] is combinational, high only for the winner and only in IDLE. All bits are 0 in other states.
  - On accept: latch operand, format, sign and id; set pointer = (winner+1) mod NREQ.
- Formats, operand n:
  - 000: out_data = {4'b0, sign, n[6:0]}.
  - 001: out_data = {4'b0, ~n}.
  - 010: out_data = {4'b0, (~n+1) mod 256}; n=0 gives 0.
  - 011: 3-digit BCD of n, hundreds digit in [11:8].
  - 100: BCD, then +3 added to each nibble independently.
  - 101, 110, 111: out_data = 0, out_err = 1.
- Transitions and latency (accept at edge t):
  - Formats 000, 001, 010 and reserved: result registered at the accept edge; IDLE->DONE; out_valid at t+1.
  - Format 011: IDLE->SHIFT. SHIFT runs exactly 8 double-dabble iterations, one per cycle: add 3 to every nibble >= 5, then shift left, bringing in the next bit MSB-first. Then SHIFT->DONE; out_valid at t+9.
  - Format 100: same as 011, then SHIFT->ADJ for one cycle, then ADJ->DONE; out_valid at t+10.
- DONE:
  - out_valid held high; out_data, out_id and out_err are stable until out_valid & out_ready.
  - On that handshake, DONE->IDLE, out_valid drops the next cycle, and a new grant is possible that same IDLE cycle.
  - out_ready is ignored outside DONE.
- Throughput: at most one request accepted per 2 cycles, since there is no overlap of DONE and IDLE.
- Requester side:
  - A requester keeps req_valid and its fields stable until accepted.
  - Fields are sampled only at accept; later changes are ignored.
  - Deasserting req_valid before grant is allowed; the request is simply dropped.
- Pointer: advances only on accept; unchanged when no request is pending.
- busy = (state != IDLE).

Optional Feature:
- Macro NUM_CONV_STATS_EN.
- Defined:
  - Adds output conv_count [15:0]: count of completed output handshakes, saturating at 16'hFFFF.
  - Adds output err_count [7:0]: completed handshakes with out_err=1, saturating at 8'hFF.
  - Both counters reset to 0 by rst_n.
- Undefined: both ports and counters are absent; all other behaviour is identical.

Test Plan:
- Req0, fmt 011, n=8'd200, out_ready=1 -> out_valid exactly 9 cycles after accept; out_data=12'h200, out_id=0, out_err=0.
- Req1, fmt 100, n=8'd45 -> out_valid 10 cycles after accept; out_data=12'h378.
- Req2 fmt 010 n=8'h05 -> out_data=12'h0FB at t+1. Fmt 000 n=8'h85 sign=1 -> 12'h085; same with sign=0 -> 12'h005. Fmt 001 n=8'h0F -> 12'h0F0.
- Req0 and req2 valid simultaneously, pointer=0, out_ready=1 -> req0 granted first, then req2; pointer=3 afterwards. Next grant with all four valid goes to req3.
- out_ready=0 for 5 cycles in DONE -> out_valid, out_data and out_id stable; req_ready=0 throughout; fmt 101 result -> out_data=0, out_err=1.
- rst_n low during SHIFT iteration 4 -> out_valid=0, busy=0 immediately; after release, a fresh fmt 011 n=8'd99 request -> 12'h099, pointer restarted at 0.
